// File: rtl/address_memory_responder_pkg.sv
// Shared definitions for the address memory responder: FSM state encoding
// and the default memory geometry.
package address_memory_responder_pkg;

    // Default memory size in bytes and the matching address width.
    localparam int DEFAULT_DEPTH = 256;
    localparam int DEFAULT_ABITS = 8;

    // Access sequencer states. The encoding is fixed so that external
    // observers (debug taps, formal harnesses) can rely on it.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC0 = 2'b01,
        ACC1 = 2'b10,
        DONE = 2'b11
    } state_e;

    // True when the state is an active memory access cycle.
    function automatic logic is_access(input state_e s);
        return (s == ACC0) || (s == ACC1);
    endfunction

endpackage

// File: rtl/address_memory_responder_mem.sv
// DEPTH x 8 byte storage: one synchronous write port and one combinational
// read port sharing a single address. Deliberately has no reset, so the
// contents survive a reset of the surrounding sequencer.
module memory_byte_array #(
    parameter int DEPTH = 256,
    parameter int ABITS = 8
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ABITS-1:0] addr_i,
    input  logic [7:0]       wdata_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Byte write on the rising edge when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/address_memory_responder.sv
// Byte/word memory responder. A request accepted in IDLE is latched, then
// the sequencer walks ACC0 (byte A), optionally ACC1 (byte A+1, wrapping
// modulo DEPTH) and DONE, where Ack pulses for one cycle. Words are stored
// little-endian, one byte per cycle.
module address_memory_responder
    import address_memory_responder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int ABITS = DEFAULT_ABITS
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Address,
    input  logic [15:0] WrData,
    input  logic        Req,
    input  logic        Write,
    input  logic        Word,
    output logic [15:0] RdData,
    output logic        Ack,
    output logic        Busy
);

    state_e           state_q, state_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             write_q, write_d;
    logic             word_q, word_d;
    // Low byte of a word read is parked here so RdData only changes as the
    // whole result becomes valid on entry to DONE.
    logic [7:0]       rbuf_q, rbuf_d;
    logic [15:0]      rdata_q, rdata_d;

    logic [ABITS-1:0] mem_addr;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem_rdata;
    logic             mem_we;

    // Address bits above ABITS alias onto the same storage.
    if (ABITS < 16) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^Address[15:ABITS];
    end

    // Memory port steering: ACC1 targets the next byte, the ABITS-wide add
    // wraps DEPTH-1 back to 0. The write enable is decoded from the state
    // register so an asynchronous reset cancels any pending byte write.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q[7:0];
        if (state_q == ACC1) begin
            mem_addr  = addr_q + ABITS'(1);
            mem_wdata = wdata_q[15:8];
        end
        mem_we = write_q && is_access(state_q);
    end

    memory_byte_array #(
        .DEPTH (DEPTH),
        .ABITS (ABITS)
    ) u_mem (
        .clk_i   (Clock),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    // Next-state, request latching and read-result assembly.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        word_d  = word_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                // Req is only looked at here; requests while busy are dropped.
                if (Req) begin
                    state_d = ACC0;
                    addr_d  = Address[ABITS-1:0];
                    wdata_d = WrData;
                    write_d = Write;
                    word_d  = Word;
                end
            end
            ACC0: begin
                if (!write_q) begin
                    if (word_q) begin
                        rbuf_d = mem_rdata;
                    end else begin
                        rdata_d = {8'h00, mem_rdata};
                    end
                end
                state_d = word_q ? ACC1 : DONE;
            end
            ACC1: begin
                if (!write_q) begin
                    rdata_d = {mem_rdata, rbuf_q};
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers; reset returns to IDLE and clears the
    // read result without touching memory.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            word_q  <= 1'b0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            word_q  <= word_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
        end
    end

    assign RdData = rdata_q;
    assign Ack    = (state_q == DONE);
    assign Busy   = (state_q != IDLE);

endmodule
